// File: rtl/lenet_pkg.sv
// Shared sizing and sequencer state encoding for the LeNet accelerator layer stages.
package lenet_pkg;
  localparam int TOTAL  = 2 * 28 * 28;
  localparam int ADDR_W = $clog2(TOTAL);
  localparam int CNT_W  = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;
endpackage

// File: rtl/relu_skid_fifo.sv
// Two-entry FIFO of {address, data} pairs decoupling the fixed-latency read
// return path from the backpressured write port.
module relu_skid_fifo #(
  parameter int AW = 11,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic [1:0]    count,
  output logic          empty,
  output logic          full
);
  logic [AW-1:0] addr_mem_r [2];
  logic [DW-1:0] data_mem_r [2];
  logic          wr_ptr_r;
  logic          rd_ptr_r;
  logic [1:0]    count_r;

  // Storage, pointers and occupancy; a simultaneous push and pop keeps the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_mem_r[0] <= {AW{1'b0}};
      addr_mem_r[1] <= {AW{1'b0}};
      data_mem_r[0] <= {DW{1'b0}};
      data_mem_r[1] <= {DW{1'b0}};
      wr_ptr_r      <= 1'b0;
      rd_ptr_r      <= 1'b0;
      count_r       <= 2'd0;
    end else begin
      if (push) begin
        addr_mem_r[wr_ptr_r] <= push_addr;
        data_mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r             <= ~wr_ptr_r;
      end
      if (pop) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_addr = addr_mem_r[rd_ptr_r];
  assign head_data = data_mem_r[rd_ptr_r];
  assign count     = count_r;
  assign empty     = (count_r == 2'd0);
  assign full      = (count_r == 2'd2);
endmodule

// File: rtl/relu_layer_1_sequencer.sv
// Streams the layer-1 conv feature map through a ReLU into the activation buffer,
// one element per cycle, counting clamped elements for sparsity statistics.
module relu_layer_1_sequencer
  import lenet_pkg::*;
#(
  parameter int bitwidth = 32,
  parameter int CHANNELS = 2,
  parameter int HEIGHT   = 28,
  parameter int WIDTH    = 28
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                rd_en,
  output logic [ADDR_W-1:0]   rd_addr,
  input  logic [bitwidth-1:0] rd_data,
  output logic                wr_en,
  input  logic                wr_ready,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [bitwidth-1:0] wr_data,
  output logic [CNT_W-1:0]    zero_count
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CHANNELS * HEIGHT * WIDTH - 1);

  seq_state_t          state_r;
  seq_state_t          state_nxt_s;
  logic [ADDR_W-1:0]   rd_addr_r;
  logic [ADDR_W-1:0]   ret_addr_r;
  logic                inflight_r;
  logic [CNT_W-1:0]    zero_count_r;
  logic                push_s;
  logic                pop_s;
  logic                clamp_s;
  logic [bitwidth-1:0] relu_s;
  logic [1:0]          fifo_count_s;
  logic                empty_s;
  logic                full_s;
  logic                room_s;

  assign push_s  = inflight_r;
  assign pop_s   = wr_en && wr_ready;
  assign clamp_s = rd_data[bitwidth-1];
  assign relu_s  = clamp_s ? {bitwidth{1'b0}} : rd_data;
  assign wr_en   = !empty_s;

  // Fewer than two elements buffered or in flight; a full FIFO never has a read in flight.
  assign room_s = !full_s && !((fifo_count_s == 2'd1) && inflight_r);

  relu_skid_fifo #(
    .AW (ADDR_W),
    .DW (bitwidth)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_addr (ret_addr_r),
    .push_data (relu_s),
    .pop       (pop_s),
    .head_addr (wr_addr),
    .head_data (wr_data),
    .count     (fifo_count_s),
    .empty     (empty_s),
    .full      (full_s)
  );

  // Next-state and read-issue decode.
  always_comb begin
    state_nxt_s = state_r;
    rd_en       = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = RUN;
        else       state_nxt_s = IDLE;
      end
      RUN: begin
        rd_en = room_s || pop_s;
        if (rd_en && (rd_addr_r == LAST_ADDR)) state_nxt_s = DRAIN;
        else                                   state_nxt_s = RUN;
      end
      DRAIN: begin
        // Finish on the cycle whose handshake empties the pipeline.
        if (!inflight_r && (empty_s || ((fifo_count_s == 2'd1) && pop_s))) state_nxt_s = DONE;
        else                                                            state_nxt_s = DRAIN;
      end
      DONE: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, read address, return-path tracking and clamp counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      rd_addr_r    <= {ADDR_W{1'b0}};
      ret_addr_r   <= {ADDR_W{1'b0}};
      inflight_r   <= 1'b0;
      zero_count_r <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      inflight_r <= rd_en;
      if (rd_en) begin
        ret_addr_r <= rd_addr_r;
      end
      if ((state_r == IDLE) && start) begin
        rd_addr_r    <= {ADDR_W{1'b0}};
        zero_count_r <= {CNT_W{1'b0}};
      end else begin
        if (rd_en && (rd_addr_r != LAST_ADDR)) begin
          rd_addr_r <= rd_addr_r + ADDR_W'(1);
        end
        if (push_s && clamp_s) begin
          zero_count_r <= zero_count_r + CNT_W'(1);
        end
      end
    end
  end

  assign busy       = (state_r == RUN) || (state_r == DRAIN);
  assign done       = (state_r == DONE);
  assign rd_addr    = rd_addr_r;
  assign zero_count = zero_count_r;
endmodule

// File: tb/tb_relu_layer_1_sequencer.sv
// Self-checking bench for relu_layer_1_sequencer: buffer model with 1-cycle read
// latency, expected-write scoreboard queue, backpressure, restart and abort scenarios.
module tb_relu_layer_1_sequencer;
  localparam int N = 1568;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic        rd_en;
  logic [10:0] rd_addr;
  logic [31:0] rd_data;
  logic        wr_en;
  logic        wr_ready;
  logic [10:0] wr_addr;
  logic [31:0] wr_data;
  logic [10:0] zero_count;

  logic [31:0] mem [N];
  logic [31:0] got [N];
  logic [42:0] exp_q [$];
  int          exp_zero;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  relu_layer_1_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .zero_count (zero_count)
  );

  // Source buffer: data for a read appears the cycle after rd_en.
  always @(posedge clk) begin
    rd_data <= rd_en ? mem[rd_addr] : 32'hDEAD_BEEF;
  end

  function automatic logic [31:0] relu_ref(input logic [31:0] v);
    if ($signed(v) < 0) return 32'd0;
    return v;
  endfunction

  task automatic load_alternating();
    for (int i = 0; i < N; i++) mem[i] = (i % 2 == 0) ? 32'd5 : -32'sd5;
  endtask

  task automatic load_positive();
    for (int i = 0; i < N; i++) mem[i] = $urandom() & 32'h7FFF_FFFF;
  endtask

  // One full pass: expected writes are queued up front and popped on each handshake.
  task automatic run_pass(input int mode, input bit mid_start, input bit check_timing);
    int c, r_cnt, w_cnt, stall_left;
    bit stall_done, prev_stall, finished;
    logic [10:0] pa, a;
    logic [31:0] pd;
    logic [42:0] e;
    exp_q.delete();
    exp_zero = 0;
    for (int i = 0; i < N; i++) begin
      a = 11'(i);
      exp_q.push_back({a, relu_ref(mem[i])});
      if ($signed(mem[i]) < 0) exp_zero++;
    end
    r_cnt = 0; w_cnt = 0; stall_left = 0;
    stall_done = 0; prev_stall = 0; finished = 0;
    pa = 11'd0; pd = 32'd0;
    @(posedge clk); #1 start = 1'b1; wr_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    c = 1;
    while (!finished && c < 20000) begin
      start = (mid_start && c == 500);
      if (stall_left > 0) begin
        wr_ready = 1'b0; stall_left--;
      end else if (mode == 1 && !stall_done && wr_en && wr_addr == 11'd700) begin
        wr_ready = 1'b0; stall_left = 19; stall_done = 1;
      end else if (mode == 1) begin
        wr_ready = 1'($urandom_range(0, 1));
      end else begin
        wr_ready = 1'b1;
      end
      @(negedge clk);
      if (c == 1) begin
        n_vec++;
        if (zero_count !== 11'd0 || rd_en !== 1'b1 || rd_addr !== 11'd0)
          begin n_err++; $display("FAIL first_cycle: zc=%0d rd_en=%b rd_addr=%0d, want 0/1/0", zero_count, rd_en, rd_addr); end
      end
      if (check_timing && (c == 2 || c == 3)) begin
        n_vec++;
        if (wr_en !== (c == 3))
          begin n_err++; $display("FAIL wr_en_latency: cycle %0d wr_en=%b want %b", c, wr_en, (c == 3)); end
      end
      if (prev_stall) begin
        n_vec++;
        if (wr_en !== 1'b1 || wr_addr !== pa || wr_data !== pd)
          begin n_err++; $display("FAIL stall_hold: got %b/%0d/%h want 1/%0d/%h", wr_en, wr_addr, wr_data, pa, pd); end
      end
      if (rd_en) begin
        n_vec++;
        if (rd_addr !== 11'(r_cnt))
          begin n_err++; $display("FAIL rd_addr: got %0d want %0d", rd_addr, r_cnt); end
        r_cnt++;
      end
      if (done) begin
        n_vec++;
        if (busy !== 1'b0 || wr_en !== 1'b0 || zero_count !== 11'(exp_zero) || w_cnt != N || exp_q.size() != 0)
          begin n_err++; $display("FAIL done_state: busy=%b wr_en=%b zc=%0d writes=%0d left=%0d, want 0/0/%0d/%0d/0",
                                  busy, wr_en, zero_count, w_cnt, exp_q.size(), exp_zero, N); end
        if (check_timing) begin
          n_vec++;
          if (c != 1571) begin n_err++; $display("FAIL done_cycle: got T+%0d want T+1571", c); end
        end
        finished = 1;
      end else begin
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL busy: cycle %0d busy=%b want 1", c, busy); end
      end
      if (wr_en && wr_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL extra_write: addr %0d data %h, want none", wr_addr, wr_data);
        end else begin
          e = exp_q.pop_front();
          if ({wr_addr, wr_data} !== e)
            begin n_err++; $display("FAIL write: got %0d/%h want %0d/%h", wr_addr, wr_data, e[42:32], e[31:0]); end
        end
        got[wr_addr] = wr_data;
        w_cnt++;
      end
      n_vec++;
      if (r_cnt - w_cnt > 2) begin n_err++; $display("FAIL outstanding: got %0d want <=2", r_cnt - w_cnt); end
      prev_stall = wr_en && !wr_ready;
      pa = wr_addr; pd = wr_data;
      @(posedge clk); #1;
      c++;
    end
    if (!finished) begin n_err++; $display("FAIL timeout: no done within %0d cycles, want done", c); end
    start = 1'b0; wr_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0)
      begin n_err++; $display("FAIL after_done: done=%b busy=%b want 0/0", done, busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; wr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({busy, done, rd_en, wr_en} !== 4'b0000)
      begin n_err++; $display("FAIL reset_ctrl: got %b want 0000", {busy, done, rd_en, wr_en}); end
    n_vec++;
    if (rd_addr !== 11'd0 || wr_addr !== 11'd0 || wr_data !== 32'd0 || zero_count !== 11'd0)
      begin n_err++; $display("FAIL reset_data: got %0d/%0d/%h/%0d want 0/0/0/0", rd_addr, wr_addr, wr_data, zero_count); end
  endtask

  task automatic test_alternating();
    load_alternating();
    run_pass(0, 1'b0, 1'b1);
    n_vec++;
    if (zero_count !== 11'd784 || got[0] !== 32'd5 || got[1] !== 32'd0 || got[1567] !== 32'd0)
      begin n_err++; $display("FAIL alternating: zc=%0d d0=%h d1=%h dlast=%h want 784/5/0/0", zero_count, got[0], got[1], got[1567]); end
  endtask

  task automatic test_corners();
    for (int i = 0; i < N; i++) mem[i] = 32'(i * 7 + 3);
    mem[0] = 32'h0000_0000; mem[1] = 32'h0000_0001; mem[2] = 32'h7FFF_FFFF;
    mem[3] = 32'h8000_0000; mem[4] = 32'hFFFF_FFFF;
    run_pass(0, 1'b0, 1'b1);
    n_vec++;
    if (got[0] !== 32'd0 || got[1] !== 32'd1 || got[2] !== 32'h7FFF_FFFF || got[3] !== 32'd0 || got[4] !== 32'd0)
      begin n_err++; $display("FAIL corners: got %h %h %h %h %h want 0 1 7fffffff 0 0", got[0], got[1], got[2], got[3], got[4]); end
    n_vec++;
    if (zero_count !== 11'd2) begin n_err++; $display("FAIL corners_zc: got %0d want 2", zero_count); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < N; i++) mem[i] = $urandom();
    run_pass(1, 1'b0, 1'b0);
  endtask

  task automatic test_restart();
    load_alternating();
    run_pass(0, 1'b1, 1'b1);
    run_pass(0, 1'b0, 1'b1);
  endtask

  task automatic test_abort();
    int cnt;
    load_alternating();
    @(posedge clk); #1 start = 1'b1; wr_ready = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cnt = 0;
    while (!(wr_en && wr_addr == 11'd1000) && cnt < 5000) begin
      @(posedge clk); #1;
      cnt++;
    end
    n_vec++;
    if (cnt >= 5000) begin n_err++; $display("FAIL abort_reach: addr 1000 not seen, want seen"); end
    wr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({busy, done, rd_en, wr_en} !== 4'b0000)
      begin n_err++; $display("FAIL abort_ctrl: got %b want 0000", {busy, done, rd_en, wr_en}); end
    n_vec++;
    if (rd_addr !== 11'd0 || wr_addr !== 11'd0 || wr_data !== 32'd0 || zero_count !== 11'd0)
      begin n_err++; $display("FAIL abort_data: got %0d/%0d/%h/%0d want 0/0/0/0", rd_addr, wr_addr, wr_data, zero_count); end
    wr_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0 || busy !== 1'b0 || wr_en !== 1'b0)
        begin n_err++; $display("FAIL abort_quiet: done=%b busy=%b wr_en=%b want 0/0/0", done, busy, wr_en); end
    end
    run_pass(0, 1'b0, 1'b1);
  endtask

  task automatic test_all_positive();
    load_positive();
    run_pass(0, 1'b0, 1'b1);
    n_vec++;
    if (zero_count !== 11'd0) begin n_err++; $display("FAIL positive_zc: got %0d want 0", zero_count); end
  endtask

  initial begin
    test_reset();
    test_alternating();
    test_corners();
    test_backpressure();
    test_restart();
    test_abort();
    test_all_positive();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
